// File: rtl/display_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : display_pkg
//  Description : Shared constants for the OUT display back end: slot/digit
//                counts, active-low seven-segment glyphs ({g,f,e,d,c,b,a})
//                and the digit-enable helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package display_pkg;

    localparam int NUM_SLOTS  = 8;
    localparam int NUM_DIGITS = 8;

    // 16-bit value held in one capture slot
    typedef logic [15:0] slot_t;

    // Active-low glyphs; a cleared bit lights the segment
    localparam logic [6:0] SEG7_BLANK = 7'h7F;
    localparam logic [6:0] SEG7_0     = 7'h40;
    localparam logic [6:0] SEG7_1     = 7'h79;
    localparam logic [6:0] SEG7_2     = 7'h24;
    localparam logic [6:0] SEG7_3     = 7'h30;
    localparam logic [6:0] SEG7_4     = 7'h19;
    localparam logic [6:0] SEG7_5     = 7'h12;
    localparam logic [6:0] SEG7_6     = 7'h02;
    localparam logic [6:0] SEG7_7     = 7'h78;
    localparam logic [6:0] SEG7_8     = 7'h00;
    localparam logic [6:0] SEG7_9     = 7'h10;
    localparam logic [6:0] SEG7_A     = 7'h08;
    localparam logic [6:0] SEG7_B     = 7'h03;
    localparam logic [6:0] SEG7_C     = 7'h46;
    localparam logic [6:0] SEG7_D     = 7'h21;
    localparam logic [6:0] SEG7_E     = 7'h06;
    localparam logic [6:0] SEG7_F     = 7'h0E;

    // All anodes off
    localparam logic [7:0] AN_ALL_OFF = 8'hFF;

    // One-hot-low anode pattern for the given digit index
    function automatic logic [7:0] digit_enable_n(input logic [2:0] idx);
        logic [7:0] one;
        one = 8'b0000_0001;
        return ~(one << idx);
    endfunction

endpackage : display_pkg
`default_nettype wire

// File: rtl/hex_to_seg7.sv
`default_nettype none
// ============================================================================
//  Module      : hex_to_seg7
//  Description : Combinational 4-bit nibble to active-low seven-segment
//                decoder. Lower-case b and d keep 8/B and 0/D distinct.
//  Revision    : 1.0 - initial release
// ============================================================================
module hex_to_seg7
    import display_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg_n
);

    // Glyph lookup for one hex digit
    always_comb begin
        seg_n = SEG7_BLANK;
        case (nibble)
            4'h0:    seg_n = SEG7_0;
            4'h1:    seg_n = SEG7_1;
            4'h2:    seg_n = SEG7_2;
            4'h3:    seg_n = SEG7_3;
            4'h4:    seg_n = SEG7_4;
            4'h5:    seg_n = SEG7_5;
            4'h6:    seg_n = SEG7_6;
            4'h7:    seg_n = SEG7_7;
            4'h8:    seg_n = SEG7_8;
            4'h9:    seg_n = SEG7_9;
            4'hA:    seg_n = SEG7_A;
            4'hB:    seg_n = SEG7_B;
            4'hC:    seg_n = SEG7_C;
            4'hD:    seg_n = SEG7_D;
            4'hE:    seg_n = SEG7_E;
            4'hF:    seg_n = SEG7_F;
            default: seg_n = SEG7_BLANK;
        endcase
    end

endmodule : hex_to_seg7
`default_nettype wire

// File: rtl/out_display_unit.sv
`default_nettype none
// ============================================================================
//  Module      : out_display_unit
//  Description : OUT-path back end. Captures processor OUT events into eight
//                16-bit slots and scans two of them (one page) onto an
//                8-digit multiplexed active-low seven-segment display.
//                Decimal points blink while the processor is halted.
//  Revision    : 1.0 - initial release
// ============================================================================
module out_display_unit
    import display_pkg::*;
#(
    parameter int SCAN_DIV  = 50000,   // clock cycles per digit, >= 2
    parameter int BLINK_DIV = 256      // full scan rounds per blink toggle, >= 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] outval1,
    input  logic [15:0] outval2,
    input  logic [2:0]  outsel,
    input  logic        outdisplay,
    input  logic        halting,
    input  logic [1:0]  page,
    output logic [6:0]  seg_n,
    output logic        dp_n,
    output logic [7:0]  an_n,
    output logic [15:0] aux_last,
    output logic [7:0]  write_count
);

    localparam int PRESC_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int ROUND_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(SCAN_DIV - 1);
    localparam logic [ROUND_W-1:0] ROUND_LAST = ROUND_W'(BLINK_DIV - 1);
    localparam logic [7:0]         COUNT_MAX  = 8'hFF;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    slot_t              slot_q [NUM_SLOTS];
    slot_t              slot_d [NUM_SLOTS];
    logic [15:0]        aux_last_q,    aux_last_d;
    logic [7:0]         write_count_q, write_count_d;

    logic [PRESC_W-1:0] presc_q,  presc_d;
    logic [2:0]         digit_q,  digit_d;
    logic [ROUND_W-1:0] round_q,  round_d;
    logic               blink_q,  blink_d;

    logic [6:0]         seg_n_q,  seg_n_d;
    logic [7:0]         an_n_q,   an_n_d;
    logic               dp_n_q,   dp_n_d;

    // Display datapath
    logic [2:0]         disp_slot_idx;
    slot_t              disp_slot;
    logic [3:0]         disp_nibble;
    logic [6:0]         disp_seg_n;

    // ------------------------------------------------------------------
    // Capture: every strobe is accepted; a repeat write to the same slot
    // simply overwrites, so the last value wins.
    // ------------------------------------------------------------------
    always_comb begin
        slot_d        = slot_q;
        aux_last_d    = aux_last_q;
        write_count_d = write_count_q;
        if (outdisplay) begin
            slot_d[outsel] = outval1;
            aux_last_d     = outval2;
            if (write_count_q != COUNT_MAX) begin
                write_count_d = write_count_q + 8'd1;
            end
        end
    end

    // Capture registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                slot_q[i] <= '0;
            end
            aux_last_q    <= '0;
            write_count_q <= '0;
        end else begin
            slot_q        <= slot_d;
            aux_last_q    <= aux_last_d;
            write_count_q <= write_count_d;
        end
    end

    // ------------------------------------------------------------------
    // Scan timing: prescaler -> digit index -> round counter -> blink.
    // The blink flips as the round counter rolls back to zero, which with
    // BLINK_DIV = 1 is every completed 8-digit round.
    // ------------------------------------------------------------------
    always_comb begin
        presc_d = presc_q + PRESC_W'(1);
        digit_d = digit_q;
        round_d = round_q;
        blink_d = blink_q;
        if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            digit_d = digit_q + 3'd1;
            if (digit_q == 3'd7) begin
                if (round_q == ROUND_LAST) begin
                    round_d = '0;
                    blink_d = ~blink_q;
                end else begin
                    round_d = round_q + ROUND_W'(1);
                end
            end
        end
    end

    // Scan timing registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            presc_q <= '0;
            digit_q <= '0;
            round_q <= '0;
            blink_q <= 1'b0;
        end else begin
            presc_q <= presc_d;
            digit_q <= digit_d;
            round_q <= round_d;
            blink_q <= blink_d;
        end
    end

    // ------------------------------------------------------------------
    // Digit selection: digits 0..3 come from the even slot of the page,
    // 4..7 from the odd slot, so the slot index is {page, digit[2]}.
    // ------------------------------------------------------------------
    always_comb begin
        disp_slot_idx = {page, digit_q[2]};
        disp_slot     = slot_q[disp_slot_idx];
        disp_nibble   = 4'h0;
        case (digit_q[1:0])
            2'd0:    disp_nibble = disp_slot[3:0];
            2'd1:    disp_nibble = disp_slot[7:4];
            2'd2:    disp_nibble = disp_slot[11:8];
            2'd3:    disp_nibble = disp_slot[15:12];
            default: disp_nibble = 4'h0;
        endcase
    end

    hex_to_seg7 u_hex (
        .nibble (disp_nibble),
        .seg_n  (disp_seg_n)
    );

    // Next output pattern, recomputed every cycle without blanking
    always_comb begin
        seg_n_d = disp_seg_n;
        an_n_d  = digit_enable_n(digit_q);
        dp_n_d  = ~(halting & blink_q);
    end

    // Output registers keep the pad drivers glitch-free
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            seg_n_q <= SEG7_BLANK;
            an_n_q  <= AN_ALL_OFF;
            dp_n_q  <= 1'b1;
        end else begin
            seg_n_q <= seg_n_d;
            an_n_q  <= an_n_d;
            dp_n_q  <= dp_n_d;
        end
    end

    assign seg_n       = seg_n_q;
    assign an_n        = an_n_q;
    assign dp_n        = dp_n_q;
    assign aux_last    = aux_last_q;
    assign write_count = write_count_q;

endmodule : out_display_unit
`default_nettype wire

// File: tb/tb_out_display_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_out_display_unit
//  Description : Self-checking bench for out_display_unit. A scan-rate
//                instance (SCAN_DIV=4, BLINK_DIV=2) and a fast-blink
//                instance (SCAN_DIV=2, BLINK_DIV=1) share all inputs.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_out_display_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] outval1, outval2;
    logic [2:0]  outsel;
    logic        outdisplay, halting;
    logic [1:0]  page;

    logic [6:0]  seg_n,  b_seg_n;
    logic        dp_n,   b_dp_n;
    logic [7:0]  an_n,   b_an_n;
    logic [15:0] aux_last, b_aux_last;
    logic [7:0]  write_count, b_write_count;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    out_display_unit #(.SCAN_DIV(4), .BLINK_DIV(2)) u_dut (
        .clock(clock), .reset(reset), .outval1(outval1), .outval2(outval2),
        .outsel(outsel), .outdisplay(outdisplay), .halting(halting), .page(page),
        .seg_n(seg_n), .dp_n(dp_n), .an_n(an_n), .aux_last(aux_last),
        .write_count(write_count)
    );

    out_display_unit #(.SCAN_DIV(2), .BLINK_DIV(1)) u_blk (
        .clock(clock), .reset(reset), .outval1(outval1), .outval2(outval2),
        .outsel(outsel), .outdisplay(outdisplay), .halting(halting), .page(page),
        .seg_n(b_seg_n), .dp_n(b_dp_n), .an_n(b_an_n), .aux_last(b_aux_last),
        .write_count(b_write_count)
    );

    typedef struct { logic [1:0] page; logic [2:0] digit; logic [6:0] seg; } vec_t;
    typedef struct { logic [7:0] an; logic [6:0] seg; logic dp; } exp_t;

    vec_t vecs [24];
    exp_t sb_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One full cycle: returns at the following falling edge
    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    function automatic logic [7:0] an_for(input int d);
        logic [7:0] one;
        one = 8'b0000_0001;
        return ~(one << d);
    endfunction

    task automatic push_vecs(input int first, input int last);
        for (int i = first; i <= last; i++) begin
            exp_t e;
            e.an  = an_for(int'(vecs[i].digit));
            e.seg = vecs[i].seg;
            e.dp  = 1'b1;
            sb_q.push_back(e);
        end
    endtask

    // Pop each expected digit, wait (bounded) for it to be scanned, compare
    task automatic drain();
        while (sb_q.size() > 0) begin
            exp_t e;
            bit   found;
            e = sb_q.pop_front();
            found = 1'b0;
            for (int c = 0; c < 40 && !found; c++) begin
                if (an_n === e.an) found = 1'b1;
                else tick();
            end
            check("scan_reached", 32'(found), 32'd1);
            if (found) begin
                check("seg_n", 32'(seg_n), 32'(e.seg));
                check("dp_n", 32'(dp_n), 32'(e.dp));
            end
        end
    endtask

    task automatic strobe(input logic [2:0] sel, input logic [15:0] v1, input logic [15:0] v2);
        outsel = sel; outval1 = v1; outval2 = v2; outdisplay = 1'b1;
        tick();
        outdisplay = 1'b0;
    endtask

    // Cycles until b_dp_n (sel=0) or dp_n (sel=1) next changes, capped at limit
    task automatic dp_edge(input bit sel, input int limit, output int cycles);
        logic prev;
        prev = sel ? dp_n : b_dp_n;
        cycles = 0;
        while (cycles < limit && (sel ? dp_n : b_dp_n) === prev) begin
            tick();
            cycles++;
        end
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        // page 0 after writing BEEF to slot 1
        vecs[0]  = '{2'd0, 3'd0, 7'h40}; vecs[1]  = '{2'd0, 3'd1, 7'h40};
        vecs[2]  = '{2'd0, 3'd2, 7'h40}; vecs[3]  = '{2'd0, 3'd3, 7'h40};
        vecs[4]  = '{2'd0, 3'd4, 7'h0E}; vecs[5]  = '{2'd0, 3'd5, 7'h06};
        vecs[6]  = '{2'd0, 3'd6, 7'h06}; vecs[7]  = '{2'd0, 3'd7, 7'h03};
        // page 3 after writing 1234 to slot 6
        vecs[8]  = '{2'd3, 3'd0, 7'h19}; vecs[9]  = '{2'd3, 3'd1, 7'h30};
        vecs[10] = '{2'd3, 3'd2, 7'h24}; vecs[11] = '{2'd3, 3'd3, 7'h79};
        vecs[12] = '{2'd3, 3'd4, 7'h40}; vecs[13] = '{2'd3, 3'd5, 7'h40};
        vecs[14] = '{2'd3, 3'd6, 7'h40}; vecs[15] = '{2'd3, 3'd7, 7'h40};
        // page 1 after collision test: slot2=0002, slot3=C0DE
        vecs[16] = '{2'd1, 3'd0, 7'h24}; vecs[17] = '{2'd1, 3'd1, 7'h40};
        vecs[18] = '{2'd1, 3'd2, 7'h40}; vecs[19] = '{2'd1, 3'd3, 7'h40};
        vecs[20] = '{2'd1, 3'd4, 7'h06}; vecs[21] = '{2'd1, 3'd5, 7'h21};
        vecs[22] = '{2'd1, 3'd6, 7'h40}; vecs[23] = '{2'd1, 3'd7, 7'h46};

        reset = 1'b1; outval1 = '0; outval2 = '0; outsel = '0;
        outdisplay = 1'b0; halting = 1'b0; page = 2'd0;
        repeat (3) @(negedge clock);
        check("reset_an_n", 32'(an_n), 32'hFF);
        check("reset_seg_n", 32'(seg_n), 32'h7F);
        check("reset_dp_n", 32'(dp_n), 32'd1);
        reset = 1'b0;
        tick();

        // Single write, page 0
        strobe(3'd1, 16'hBEEF, 16'h5555);
        page = 2'd0;
        tick(); tick();
        push_vecs(0, 7);
        drain();

        // Page select
        strobe(3'd6, 16'h1234, 16'h6666);
        page = 2'd3;
        tick(); tick();
        push_vecs(8, 15);
        drain();
        check("wc_two", 32'(write_count), 32'd2);

        // Asynchronous reset mid-cycle
        #2 reset = 1'b1;
        #1;
        check("midrst_an_n", 32'(an_n), 32'hFF);
        check("midrst_seg_n", 32'(seg_n), 32'h7F);
        check("midrst_dp_n", 32'(dp_n), 32'd1);
        check("midrst_wc", 32'(write_count), 32'd0);
        check("midrst_aux", 32'(aux_last), 32'd0);
        @(negedge clock);
        tick();
        reset = 1'b0;
        // Scan restarts at digit 0 and steps every 4 cycles; slots are all zero
        for (int n = 1; n <= 32; n++) begin
            tick();
            check("an_step", 32'(an_n), 32'(an_for((n - 1) / 4)));
            check("seg_zero", 32'(seg_n), 32'h40);
        end
        for (int p = 0; p < 3; p++) begin
            page = 2'(p);
            tick(); tick();
            for (int d = 0; d < 8; d++) begin
                exp_t e;
                e.an = an_for(d); e.seg = 7'h40; e.dp = 1'b1;
                sb_q.push_back(e);
            end
            drain();
        end

        // Write collision and back-to-back strobes
        outdisplay = 1'b1;
        outsel = 3'd2; outval1 = 16'h0001; outval2 = 16'h1111; tick();
        outsel = 3'd2; outval1 = 16'h0002; outval2 = 16'h2222; tick();
        outsel = 3'd3; outval1 = 16'hC0DE; outval2 = 16'hAAAA; tick();
        outdisplay = 1'b0;
        tick();
        check("collide_wc", 32'(write_count), 32'd3);
        check("collide_aux", 32'(aux_last), 32'hAAAA);
        page = 2'd1;
        tick();
        push_vecs(16, 23);
        drain();

        // Saturation
        outdisplay = 1'b1; outsel = 3'd7;
        for (int i = 0; i < 300; i++) begin
            outval1 = 16'(i); outval2 = 16'(i + 16'h100);
            tick();
            if (i == 99) check("wc_mid", 32'(write_count), 32'd103);
            if (i == 251) check("wc_reach", 32'(write_count), 32'd255);
        end
        outdisplay = 1'b0;
        tick();
        check("wc_sat", 32'(write_count), 32'd255);
        check("aux_final", 32'(aux_last), 32'(16'd299 + 16'h100));

        // Halt blink
        halting = 1'b1;
        dp_edge(1'b0, 40, cyc);
        check("blink_start", 32'(cyc < 40), 32'd1);
        for (int k = 0; k < 2; k++) begin
            dp_edge(1'b0, 40, cyc);
            check("blink_period", 32'(cyc), 32'd16);
        end
        dp_edge(1'b1, 140, cyc);
        check("dut_blink_start", 32'(cyc < 140), 32'd1);
        dp_edge(1'b1, 140, cyc);
        check("dut_blink_period", 32'(cyc), 32'd64);

        cyc = 0;
        while (b_dp_n !== 1'b0 && cyc < 40) begin
            tick();
            cyc++;
        end
        check("blink_low_seen", 32'(b_dp_n), 32'd0);
        halting = 1'b0;
        tick();
        check("halt_release_dp", 32'(b_dp_n), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_out_display_unit
`default_nettype wire
